// File: rtl/tawas_thread_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tawas_thread_sched
//  Purpose  : Round-robin fetch thread scheduler with per-thread PC file,
//             start/halt control and live-thread count for the Tawas core.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module tawas_thread_sched #(
    parameter int                  THREADS    = 32,
    parameter int                  AW         = 24,
    parameter logic [THREADS-1:0]  RST_ACTIVE = {THREADS{1'b1}},
    localparam int                 TW         = $clog2(THREADS)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               fetch_stall,
    output logic               ics,
    output logic [AW-1:0]      iaddr,
    output logic               ihalf,
    output logic [TW-1:0]      isel,

    input  logic               pc_update_en,
    input  logic [TW-1:0]      pc_update_sel,
    input  logic [AW:0]        pc_update_addr,
    input  logic               pc_update_halt,

    input  logic               retire_en,
    input  logic [TW-1:0]      retire_sel,

    input  logic               start_en,
    input  logic [TW-1:0]      start_sel,
    input  logic [AW-1:0]      start_pc,
    output logic               start_err,

    output logic [THREADS-1:0] thread_active,
    output logic [THREADS-1:0] thread_busy,
    output logic [TW:0]        active_cnt
);

    function automatic logic [TW:0] popcnt(input logic [THREADS-1:0] v);
        logic [TW:0] n;
        n = '0;
        for (int i = 0; i < THREADS; i++) begin
            n = n + (TW+1)'(v[i]);
        end
        return n;
    endfunction

    localparam logic [TW:0] RST_CNT = popcnt(RST_ACTIVE);

    logic [AW:0]        pc_q [THREADS];
    logic [AW:0]        pc_d [THREADS];
    logic [THREADS-1:0] active_q, active_d;
    logic [THREADS-1:0] busy_q, busy_d;
    logic [TW-1:0]      ptr_q, ptr_d;
    logic               ics_q, ics_d;
    logic [AW-1:0]      iaddr_q, iaddr_d;
    logic               ihalf_q, ihalf_d;
    logic [TW-1:0]      isel_q, isel_d;
    logic               start_err_q, start_err_d;
    logic [TW:0]        active_cnt_q, active_cnt_d;

    logic [THREADS-1:0] eligible;
    logic [TW-1:0]      cand;
    logic [TW-1:0]      gnt_idx;
    logic               gnt_found;
    logic               grant;
    logic               start_ok;

    // Round-robin search: first eligible thread at or after ptr, wrapping.
    // THREADS is a power of two, so TW-bit addition wraps naturally.
    always_comb begin
        eligible  = active_q & ~busy_q;
        cand      = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            cand = ptr_q + TW'(i);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        grant = gnt_found & ~fetch_stall;
    end

    always_comb begin
        pc_d         = pc_q;
        active_d     = active_q;
        busy_d       = busy_q;
        ptr_d        = ptr_q;
        ics_d        = 1'b0;
        iaddr_d      = iaddr_q;
        ihalf_d      = ihalf_q;
        isel_d       = isel_q;
        start_ok     = start_en && !active_q[start_sel] && !busy_q[start_sel]
                       && !(pc_update_en && (pc_update_sel == start_sel));
        start_err_d  = start_en & ~start_ok;

        // Grant reads the PC as it stood before this edge's write-back.
        if (grant) begin
            busy_d[gnt_idx]    = 1'b1;
            ptr_d              = gnt_idx + TW'(1);
            ics_d              = 1'b1;
            isel_d             = gnt_idx;
            {ihalf_d, iaddr_d} = pc_q[gnt_idx];
        end

        if (retire_en) begin
            busy_d[retire_sel] = 1'b0;
        end

        if (pc_update_en) begin
            pc_d[pc_update_sel] = pc_update_addr;
            if (pc_update_halt) begin
                active_d[pc_update_sel] = 1'b0;
            end
        end

        if (start_ok) begin
            pc_d[start_sel]     = {1'b0, start_pc};
            active_d[start_sel] = 1'b1;
        end

        active_cnt_d = popcnt(active_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < THREADS; i++) begin
                pc_q[i] <= (AW+1)'(i);
            end
            active_q     <= RST_ACTIVE;
            busy_q       <= '0;
            ptr_q        <= '0;
            ics_q        <= 1'b0;
            iaddr_q      <= '0;
            ihalf_q      <= 1'b0;
            isel_q       <= '0;
            start_err_q  <= 1'b0;
            active_cnt_q <= RST_CNT;
        end else begin
            pc_q         <= pc_d;
            active_q     <= active_d;
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
            ics_q        <= ics_d;
            iaddr_q      <= iaddr_d;
            ihalf_q      <= ihalf_d;
            isel_q       <= isel_d;
            start_err_q  <= start_err_d;
            active_cnt_q <= active_cnt_d;
        end
    end

    assign ics           = ics_q;
    assign iaddr         = iaddr_q;
    assign ihalf         = ihalf_q;
    assign isel          = isel_q;
    assign start_err     = start_err_q;
    assign thread_active = active_q;
    assign thread_busy   = busy_q;
    assign active_cnt    = active_cnt_q;

endmodule
`default_nettype wire
